// File: rtl/gol_stepper.sv
// gol_stepper: in-place Game of Life generation engine for the row register file.
// Ports: ph2 clock; reset synchronous active-low; start requests one generation.
//        ra/rd combinational read port; regwrite/wa/wd write port.
//        busy during LOAD_TOP/LOAD_CUR/RUN; done for the single DONE cycle.
//        stable means the last generation changed no row; gen_count counts generations mod 2^16.
// Build option GOL_TORUS_EN: rows and columns wrap around (torus); default has a dead border.
module gol_stepper #(
  parameter int WIDTH = 8,
  parameter int REGBITS = 3
) (
  input  logic               ph2,
  input  logic               reset,
  input  logic               start,
  output logic [REGBITS-1:0] ra,
  input  logic [WIDTH-1:0]   rd,
  output logic               regwrite,
  output logic [REGBITS-1:0] wa,
  output logic [WIDTH-1:0]   wd,
  output logic               busy,
  output logic               done,
  output logic               stable,
  output logic [15:0]        gen_count
);
  typedef enum logic [2:0] {IDLE, LOAD_TOP, LOAD_CUR, RUN, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] prev, cur, nxt;
  logic [REGBITS-1:0] r;
  logic diff, last, run;
`ifdef GOL_TORUS_EN
  logic [WIDTH-1:0] row0_save;
`endif

  // Each row is widened by one column on each side so every cell sees
  // columns c-1..c+1 at indices c..c+2; the pad is either dead or wrapped.
  function automatic logic [WIDTH-1:0] rule(input logic [WIDTH-1:0] p, c, n);
    logic [WIDTH+1:0] pe, ce, ne;
    logic [3:0] cnt;
    logic [WIDTH-1:0] res;
`ifdef GOL_TORUS_EN
    pe = {p[0], p, p[WIDTH-1]};
    ce = {c[0], c, c[WIDTH-1]};
    ne = {n[0], n, n[WIDTH-1]};
`else
    pe = {1'b0, p, 1'b0};
    ce = {1'b0, c, 1'b0};
    ne = {1'b0, n, 1'b0};
`endif
    res = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt = 4'(pe[i]) + 4'(pe[i+1]) + 4'(pe[i+2]) + 4'(ce[i]) + 4'(ce[i+2])
          + 4'(ne[i]) + 4'(ne[i+1]) + 4'(ne[i+2]);
      res[i] = (cnt == 4'd3) | (c[i] & (cnt == 4'd2));
    end
    return res;
  endfunction

  assign last = &r;
  assign run = state == RUN;

  always_comb begin
    state_n = IDLE;
    state_n = state == IDLE     ? (start ? LOAD_TOP : IDLE) :
              state == LOAD_TOP ? LOAD_CUR :
              state == LOAD_CUR ? RUN :
              state == RUN      ? (last ? DONE : RUN) :
              state == DONE     ? (start ? LOAD_TOP : IDLE) : IDLE;
  end

  always_comb begin
    nxt = '0;
`ifdef GOL_TORUS_EN
    nxt = last ? row0_save : rd;
`else
    nxt = last ? '0 : rd;
`endif
    busy = state == LOAD_TOP || state == LOAD_CUR || run;
    done = state == DONE;
    regwrite = run;
    ra = state == LOAD_TOP ? '1 : run ? REGBITS'(r + 1'b1) : '0;
    wa = run ? r : '0;
    wd = run ? rule(prev, cur, nxt) : '0;
  end

  always_ff @(posedge ph2) begin
    if (!reset) begin
      state <= IDLE;
      prev <= '0;
      cur <= '0;
      r <= '0;
      diff <= 1'b0;
      stable <= 1'b0;
      gen_count <= '0;
`ifdef GOL_TORUS_EN
      row0_save <= '0;
`endif
    end else begin
      state <= state_n;
      if (state == LOAD_TOP) begin
`ifdef GOL_TORUS_EN
        prev <= rd;
`else
        prev <= '0;
`endif
        diff <= 1'b0;
      end
      if (state == LOAD_CUR) begin
        cur <= rd;
        r <= '0;
`ifdef GOL_TORUS_EN
        row0_save <= rd;
`endif
      end
      if (run) begin
        prev <= cur;
        cur <= nxt;
        diff <= diff | (wd != cur);
        if (!last) r <= REGBITS'(r + 1'b1);
      end
      if (state == DONE) begin
        gen_count <= gen_count + 16'd1;
        stable <= ~diff;
      end
    end
  end
endmodule

// File: tb/tb_gol_stepper.sv
// tb_gol_stepper: directed and random generations checked against a whole-board life model
module tb_gol_stepper;
  localparam int W = 8;
  localparam int N = 8;
  logic ph2, reset, start, regwrite, busy, done, stable;
  logic [2:0] ra, wa;
  logic [7:0] rd, wd;
  logic [15:0] gen_count;
  logic [7:0] mem [N];
  logic ld_en;
  logic [2:0] ld_a;
  logic [7:0] ld_d;
  logic [7:0] ref_b [N];
  logic [7:0] orig [N];
  int vectors = 0;
  int miscompares = 0;
  int exp_gc = 0;
  bit ch;

  gol_stepper dut (
    .ph2(ph2), .reset(reset), .start(start), .ra(ra), .rd(rd),
    .regwrite(regwrite), .wa(wa), .wd(wd), .busy(busy), .done(done),
    .stable(stable), .gen_count(gen_count)
  );

  initial ph2 = 1'b0;
  always #5 ph2 = ~ph2;

  assign rd = mem[ra];
  always @(posedge ph2) begin
    if (ld_en) mem[ld_a] <= ld_d;
    else if (regwrite) mem[wa] <= wd;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Next generation of the whole board from neighbour counts over the 3x3 window.
  task automatic model_step(output bit changed);
    logic [7:0] nb [N];
    int n, rr, cc;
    changed = 0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < W; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr == 0 && dc == 0) continue;
            rr = r + dr;
            cc = c + dc;
`ifdef GOL_TORUS_EN
            rr = (rr + N) % N;
            cc = (cc + W) % W;
`endif
            if (rr >= 0 && rr < N && cc >= 0 && cc < W) n += int'(ref_b[rr][cc]);
          end
        end
        nb[r][c] = (n == 3) || (ref_b[r][c] && n == 2);
      end
    end
    for (int r = 0; r < N; r++) begin
      if (nb[r] != ref_b[r]) changed = 1;
      ref_b[r] = nb[r];
    end
  endtask

  task automatic load_ref();
    for (int i = 0; i < N; i++) begin
      ld_en = 1;
      ld_a = 3'(i);
      ld_d = ref_b[i];
      @(negedge ph2);
    end
    ld_en = 0;
  endtask

  task automatic check_board();
    for (int i = 0; i < N; i++) check($sformatf("row%0d", i), mem[i], ref_b[i]);
  endtask

  task automatic gen(input bit timing);
    int dc;
    dc = 0;
    start = 1;
    for (int k = 1; k <= 30 && dc == 0; k++) begin
      @(negedge ph2);
      start = 0;
      if (timing) begin
        check("busy", busy, k <= N + 2);
        check("regwrite", regwrite, k >= 3 && k <= N + 2);
        if (regwrite) check("wa_order", wa, k - 3);
      end
      if (done) dc = k;
    end
    check("done_cycle", dc, N + 3);
    @(negedge ph2);
  endtask

  task automatic gen_and_check(input bit timing);
    gen(timing);
    model_step(ch);
    exp_gc++;
    check("gen_count", gen_count, exp_gc);
    check("stable", stable, !ch);
    check_board();
  endtask

  initial begin
    reset = 0;
    start = 0;
    ld_en = 0;
    ld_a = 0;
    ld_d = 0;
    repeat (2) @(negedge ph2);
    check("rst_ra", ra, 0);
    check("rst_wa", wa, 0);
    check("rst_wd", wd, 0);
    check("rst_regwrite", regwrite, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_stable", stable, 0);
    check("rst_gen_count", gen_count, 0);
    reset = 1;
    @(negedge ph2);

    for (int i = 0; i < N; i++) ref_b[i] = 8'h00;
    ref_b[2] = 8'b00011100;
    load_ref();
    gen_and_check(1);
    check("blinker_r1", mem[1], 8'b00001000);
    check("blinker_r2", mem[2], 8'b00001000);
    check("blinker_r3", mem[3], 8'b00001000);
    check("blinker_stable", stable, 0);
    gen_and_check(0);
    check("blinker_back", mem[2], 8'b00011100);

    for (int i = 0; i < N; i++) ref_b[i] = 8'h00;
    ref_b[3] = 8'b00011000;
    ref_b[4] = 8'b00011000;
    load_ref();
    gen_and_check(1);
    check("block_stable", stable, 1);

    for (int i = 0; i < N; i++) ref_b[i] = 8'h00;
    ref_b[7] = 8'b10000011;
    load_ref();
    gen_and_check(0);
`ifdef GOL_TORUS_EN
    check("edge_r6", mem[6], 8'b00000001);
    check("edge_r7", mem[7], 8'b00000001);
    check("edge_r0", mem[0], 8'b00000001);
`else
    check("edge_r7", mem[7], 8'b00000000);
`endif

    for (int i = 0; i < N; i++) ref_b[i] = 8'($urandom);
    load_ref();
    start = 1;
    for (int k = 1; k <= 3 * (N + 3); k++) begin
      @(negedge ph2);
      check("b2b_done", done, k % (N + 3) == 0);
      check("b2b_busy", busy, k % (N + 3) != 0);
      if (k == 3 * (N + 3)) start = 0;
    end
    @(negedge ph2);
    for (int g = 0; g < 3; g++) model_step(ch);
    exp_gc += 3;
    check("b2b_gen_count", gen_count, exp_gc);
    check("b2b_stable", stable, !ch);
    check_board();

    for (int i = 0; i < N; i++) ref_b[i] = 8'($urandom);
    load_ref();
    start = 1;
    for (int k = 1; k <= N + 3; k++) begin
      @(negedge ph2);
      start = (k == 5);
    end
    check("ign_done", done, 1);
    start = 0;
    @(negedge ph2);
    check("ign_idle1", busy, 0);
    @(negedge ph2);
    check("ign_idle2", busy, 0);
    model_step(ch);
    exp_gc++;
    check("ign_gen_count", gen_count, exp_gc);
    check_board();

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < N; i++) ref_b[i] = 8'($urandom);
      load_ref();
      gen_and_check(t == 0);
    end

    for (int i = 0; i < N; i++) begin
      ref_b[i] = 8'($urandom);
      orig[i] = ref_b[i];
    end
    load_ref();
    start = 1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge ph2);
      start = 0;
    end
    check("mid_wa", wa, 2);
    reset = 0;
    @(negedge ph2);
    check("mid_regwrite", regwrite, 0);
    check("mid_busy", busy, 0);
    check("mid_gen_count", gen_count, 0);
    check("mid_done", done, 0);
    check("mid_ra", ra, 0);
    reset = 1;
    @(negedge ph2);
    check("mid_idle", busy, 0);
    model_step(ch);
    for (int i = 3; i < N; i++) ref_b[i] = orig[i];
    check_board();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
